// File: rtl/ycbcr_coef_loader.sv
// rtl/ycbcr_coef_loader.sv - fetches a block of coefficient bytes from RAM and commits them atomically
//
// Purpose: on start, read NUM_COEF consecutive bytes from a synchronous-read
// coefficient RAM starting at base_addr (address wraps modulo 2^ADDR_W), collect
// them in shadow registers, then publish the whole set on coef_bus in a single edge.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - load request (ignored while busy)
//   base_addr  - RAM address of coefficient 0, sampled with start
//   ram_raddr  - RAM read address (holds last value while ram_re=0)
//   ram_re     - RAM read enable
//   ram_rdata  - RAM read data, one cycle after the address edge
//   busy       - load in progress
//   done       - one-cycle completion pulse
//   coef_valid - coef_bus holds a committed set
//   coef_bus   - committed coefficients, coefficient i at [DATA_W*i +: DATA_W]

module ycbcr_coef_loader #(
   parameter int NUM_COEF = 9,
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          base_addr,
   output logic [ADDR_W-1:0]          ram_raddr,
   output logic                       ram_re,
   input  logic [DATA_W-1:0]          ram_rdata,
   output logic                       busy,
   output logic                       done,
   output logic                       coef_valid,
   output logic [NUM_COEF*DATA_W-1:0] coef_bus
);

   localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [ADDR_W-1:0]           base_q, base_d;
   logic [ADDR_W-1:0]           raddr_q, raddr_d;
   logic                        done_q, done_d;
   logic                        valid_q, valid_d;
   logic [NUM_COEF*DATA_W-1:0]  bus_q;
   logic [DATA_W-1:0]           shadow_q [NUM_COEF];
   logic [ADDR_W-1:0]           fetch_addr;

   // Natural overflow of the ADDR_W-bit sum gives the modulo-2^ADDR_W wrap.
   assign fetch_addr = base_q + ADDR_W'(idx_q);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      raddr_d = raddr_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_addr;
               idx_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            raddr_d = fetch_addr;
            if (idx_q == LAST_IDX) begin
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DRAIN: begin
            state_d = COMMIT;
         end
         COMMIT: begin
            done_d  = 1'b1;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         base_q  <= '0;
         raddr_q <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         bus_q   <= '0;
         for (int i = 0; i < NUM_COEF; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         raddr_q <= raddr_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         // In FETCH with index k>0 the RAM is returning the byte for address k-1;
         // the final byte arrives during DRAIN.
         if (state_q == FETCH && idx_q != '0) begin
            shadow_q[idx_q - 1'b1] <= ram_rdata;
         end
         if (state_q == DRAIN) begin
            shadow_q[NUM_COEF-1] <= ram_rdata;
         end
         if (state_q == COMMIT) begin
            for (int i = 0; i < NUM_COEF; i++) begin
               bus_q[DATA_W*i +: DATA_W] <= shadow_q[i];
            end
         end
      end
   end

   // While fetching, present the live address; otherwise hold the last one issued.
   assign ram_raddr  = (state_q == FETCH) ? fetch_addr : raddr_q;
   assign ram_re     = (state_q == FETCH);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign coef_valid = valid_q;
   assign coef_bus   = bus_q;

endmodule

// File: tb/tb_ycbcr_coef_loader.sv
// tb/tb_ycbcr_coef_loader.sv - self-checking bench for ycbcr_coef_loader

module tb_ycbcr_coef_loader;

   localparam int NC = 9;
   localparam int AW = 9;
   localparam int DW = 8;
   localparam int LAT = NC + 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [AW-1:0]   ram_raddr;
   logic            ram_re;
   logic [DW-1:0]   ram_rdata = '0;
   logic            busy;
   logic            done;
   logic            coef_valid;
   logic [NC*DW-1:0] coef_bus;

   logic [DW-1:0]   mem [1 << AW];

   int checks = 0;
   int passes = 0;

   ycbcr_coef_loader #(.NUM_COEF(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .ram_raddr  (ram_raddr),
      .ram_re     (ram_re),
      .ram_rdata  (ram_rdata),
      .busy       (busy),
      .done       (done),
      .coef_valid (coef_valid),
      .coef_bus   (coef_bus)
   );

   always #5 clk = ~clk;

   // Synchronous-read coefficient RAM.
   always @(posedge clk) begin
      if (ram_re) ram_rdata <= mem[ram_raddr];
   end

   task automatic chk(input string name, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a load is a timeline measured in edges from the edge that
   // accepted start. Edge offsets 0..NC-1 issue addresses base+d, busy holds through
   // offset NC+1, and the committed set appears together with done at offset NC+2.
   bit              m_active = 0;
   int              m_d = 0;
   logic [AW-1:0]   m_base = '0;
   logic [AW-1:0]   m_raddr = '0;
   bit              m_busy = 0, m_done = 0, m_re = 0, m_valid = 0;
   logic [NC*DW-1:0] m_bus = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0; m_d = 0; m_base = '0; m_raddr = '0;
         m_busy = 0; m_done = 0; m_re = 0; m_valid = 0; m_bus = '0;
      end else begin
         if (!m_busy && start) begin
            m_active = 1;
            m_d = 0;
            m_base = base_addr;
         end else if (m_active) begin
            m_d++;
         end
         m_busy = m_active && (m_d <= LAT - 1);
         m_re   = m_active && (m_d < NC);
         m_done = m_active && (m_d == LAT);
         if (m_re) m_raddr = AW'((int'(m_base) + m_d) % (1 << AW));
         if (m_done) begin
            for (int i = 0; i < NC; i++)
               m_bus[DW*i +: DW] = mem[(int'(m_base) + i) % (1 << AW)];
            m_valid = 1;
            m_active = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy",       NC*DW'(busy),       NC*DW'(m_busy));
         chk("done",       NC*DW'(done),       NC*DW'(m_done));
         chk("ram_re",     NC*DW'(ram_re),     NC*DW'(m_re));
         chk("ram_raddr",  NC*DW'(ram_raddr),  NC*DW'(m_raddr));
         chk("coef_valid", NC*DW'(coef_valid), NC*DW'(m_valid));
         chk("coef_bus",   coef_bus,           m_bus);
      end
   end

   task automatic do_start(input logic [AW-1:0] b);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = b;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      if (lat == 0) begin
         checks++;
         $display("FAIL wait_done: no done pulse within 40 cycles at %0t", $time);
      end
   endtask

   task automatic count_done(input int n, output int cnt);
      cnt = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
   endtask

   initial begin
      int lat;
      int cnt;
      logic [NC*DW-1:0] first_set;

      for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
      mem[0] = 8'h51; mem[1] = 8'h5A; mem[2] = 8'hF0; mem[3] = 8'h90; mem[4] = 8'h35;
      mem[5] = 8'h22; mem[6] = 8'h28; mem[7] = 8'hF0; mem[8] = 8'h6D;

      // Reset and release.
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy",  NC*DW'(busy), '0);
      chk("reset_re",    NC*DW'(ram_re), '0);
      chk("reset_raddr", NC*DW'(ram_raddr), '0);
      chk("reset_valid", NC*DW'(coef_valid), '0);
      chk("reset_bus",   coef_bus, '0);
      repeat (4) @(negedge clk);

      // Nominal load from base 0.
      do_start(9'd0);
      wait_done(lat);
      chk("nominal_latency", NC*DW'(lat - 1), NC*DW'(LAT));
      chk("nominal_bus", coef_bus, 72'h6DF028223590F05A51);
      chk("nominal_valid", NC*DW'(coef_valid), NC*DW'(1));

      // Address wrap from 510.
      do_start(9'd510);
      wait_done(lat);
      chk("wrap_byte0", NC*DW'(coef_bus[7:0]), NC*DW'(mem[510]));
      chk("wrap_byte2", NC*DW'(coef_bus[23:16]), NC*DW'(8'h51));

      // Start while busy is ignored.
      do_start(9'd100);
      repeat (3) @(posedge clk);
      do_start(9'd200);
      wait_done(lat);
      count_done(15, cnt);
      chk("busy_start_extra_done", NC*DW'(cnt), '0);

      // Back-to-back: second start the cycle after done.
      do_start(9'd0);
      wait_done(lat);
      first_set = coef_bus;
      chk("b2b_first_set", first_set, 72'h6DF028223590F05A51);
      do_start(9'd16);
      wait_done(lat);
      chk("b2b_latency", NC*DW'(lat - 1), NC*DW'(LAT));
      chk("b2b_byte0", NC*DW'(coef_bus[7:0]), NC*DW'(mem[16]));
      chk("b2b_byte8", NC*DW'(coef_bus[71:64]), NC*DW'(mem[24]));

      // Reset in the middle of FETCH.
      do_start(9'd40);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy",  NC*DW'(busy), '0);
      chk("midrst_done",  NC*DW'(done), '0);
      chk("midrst_re",    NC*DW'(ram_re), '0);
      chk("midrst_raddr", NC*DW'(ram_raddr), '0);
      chk("midrst_valid", NC*DW'(coef_valid), '0);
      chk("midrst_bus",   coef_bus, '0);
      @(posedge clk); #1 rst = 1'b0;
      count_done(15, cnt);
      chk("midrst_no_done", NC*DW'(cnt), '0);
      do_start(9'd40);
      wait_done(lat);
      chk("post_rst_latency", NC*DW'(lat - 1), NC*DW'(LAT));
      chk("post_rst_byte0", NC*DW'(coef_bus[7:0]), NC*DW'(mem[40]));

      // Random start pulses, random bases, one asynchronous reset on the way.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         start = ($urandom_range(0, 5) == 0);
         base_addr = AW'($urandom);
         rst = (i == 200);
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
